// File: rtl/uart_mem_sequencer.sv
// Phase controller that schedules the single image RAM port across LOAD (UART RX -> RAM),
// PROC (downsampler owns the port) and SEND (RAM -> UART TX), raising fin once the frame is returned.
module uart_mem_sequencer #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8,
    parameter int IMG_BYTES = 65536,
    parameter int OUT_BYTES = 16384,
    parameter int OUT_BASE  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_data,
    output logic              ds_start,
    input  logic              ds_done,
    input  logic [ADDR_W-1:0] ds_addr,
    input  logic              ds_we,
    input  logic [DATA_W-1:0] ds_wdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_busy,
    output logic              fin,
    output logic [2:0]        state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        PROC      = 3'd2,
        SEND_RD   = 3'd3,
        SEND_LAT  = 3'd4,
        SEND_TX   = 3'd5,
        SEND_WAIT = 3'd6,
        DONE      = 3'd7
    } state_t;

    localparam logic [ADDR_W:0]   IMG_LAST = (ADDR_W+1)'(IMG_BYTES - 1);
    localparam logic [ADDR_W-1:0] OUT_LAST = ADDR_W'(OUT_BYTES - 1);
    localparam logic [ADDR_W-1:0] OUT_ADR0 = ADDR_W'(OUT_BASE);

    state_t              cur, nxt;
    logic [ADDR_W:0]     load_cnt, load_cnt_nxt;
    logic [ADDR_W-1:0]   tx_cnt, tx_cnt_nxt;
    logic                ds_start_nxt, tx_start_nxt;
    logic [DATA_W-1:0]   tx_data_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur      <= IDLE;
            load_cnt <= '0;
            tx_cnt   <= '0;
            ds_start <= 1'b0;
            tx_start <= 1'b0;
            tx_data  <= '0;
        end else begin
            cur      <= nxt;
            load_cnt <= load_cnt_nxt;
            tx_cnt   <= tx_cnt_nxt;
            ds_start <= ds_start_nxt;
            tx_start <= tx_start_nxt;
            tx_data  <= tx_data_nxt;
        end
    end

    // Handshakes are pulse based: rx_valid marks one byte for one cycle; tx_start marks tx_data
    // for one cycle and is only raised while tx_busy=0; tx_busy answers one cycle after tx_start.
    always_comb begin
        nxt          = cur;
        load_cnt_nxt = load_cnt;
        tx_cnt_nxt   = tx_cnt;
        ds_start_nxt = 1'b0;
        tx_start_nxt = 1'b0;
        tx_data_nxt  = tx_data;
        ram_addr     = '0;
        ram_we       = 1'b0;
        ram_wdata    = '0;
        case (cur)
            IDLE: begin
                if (start) begin
                    nxt          = LOAD;
                    load_cnt_nxt = '0;
                end
            end
            LOAD: begin
                ram_addr = load_cnt[ADDR_W-1:0];
                if (rx_valid) begin
                    ram_we       = 1'b1;
                    ram_wdata    = rx_data;
                    load_cnt_nxt = load_cnt + 1'b1;
                    if (load_cnt == IMG_LAST) begin
                        nxt          = PROC;
                        ds_start_nxt = 1'b1;
                    end
                end
            end
            PROC: begin
                ram_addr  = ds_addr;
                ram_we    = ds_we;
                ram_wdata = ds_wdata;
                // ds_start doubles as the first-PROC-cycle flag, where ds_done is not accepted
                if (ds_done && !ds_start) begin
                    nxt        = SEND_RD;
                    tx_cnt_nxt = '0;
                end
            end
            SEND_RD: begin
                ram_addr = OUT_ADR0 + tx_cnt;
                nxt      = SEND_LAT;
            end
            SEND_LAT: begin
                ram_addr = OUT_ADR0 + tx_cnt;
                nxt      = SEND_TX;
            end
            SEND_TX: begin
                ram_addr = OUT_ADR0 + tx_cnt;
                if (!tx_busy) begin
                    tx_data_nxt  = ram_rdata;
                    tx_start_nxt = 1'b1;
                    nxt          = SEND_WAIT;
                end
            end
            SEND_WAIT: begin
                ram_addr = OUT_ADR0 + tx_cnt;
                // tx_start is high only in the first SEND_WAIT cycle, before tx_busy can respond
                if (!tx_start && !tx_busy) begin
                    if (tx_cnt == OUT_LAST) begin
                        nxt = DONE;
                    end else begin
                        tx_cnt_nxt = tx_cnt + 1'b1;
                        nxt        = SEND_RD;
                    end
                end
            end
            DONE: begin
                if (start) begin
                    nxt          = LOAD;
                    load_cnt_nxt = '0;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    assign fin   = (cur == DONE);
    assign state = cur;

endmodule

// File: tb/tb_uart_mem_sequencer.sv
// Randomized bench for uart_mem_sequencer on a small frame: a byte-array RAM model, a UART TX
// busy model, and a reference image of RAM contents that predicts every write and every sent byte.
module tb_uart_mem_sequencer;

  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 8;
  localparam int IMG_BYTES = 16;
  localparam int OUT_BYTES = 4;
  localparam int OUT_BASE  = 0;

  logic              clk;
  logic              rst;
  logic              start;
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic              ds_start;
  logic              ds_done;
  logic [ADDR_W-1:0] ds_addr;
  logic              ds_we;
  logic [DATA_W-1:0] ds_wdata;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              tx_start;
  logic [DATA_W-1:0] tx_data;
  logic              tx_busy;
  logic              fin;
  logic [2:0]        state;

  uart_mem_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .IMG_BYTES(IMG_BYTES),
    .OUT_BYTES(OUT_BYTES), .OUT_BASE(OUT_BASE)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .ds_start(ds_start), .ds_done(ds_done), .ds_addr(ds_addr), .ds_we(ds_we),
    .ds_wdata(ds_wdata), .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .fin(fin), .state(state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- environment models ----------------
  logic [7:0] ram [0:255];
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr[7:0]] <= ram_wdata;
    ram_rdata <= ram[ram_addr[7:0]];
  end

  int tx_hold = 2;
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        @(posedge clk);
        #1 tx_busy = 1'b1;
        repeat (tx_hold) @(posedge clk);
        #1 tx_busy = 1'b0;
      end
    end
  end

  // ---------------- reference model and scoreboard ----------------
  logic [7:0]  ref_mem [0:255];
  logic [23:0] exp_q [$];
  logic [7:0]  tx_q [$];
  logic [7:0]  last_tx = '0;
  int          n_tx = 0;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (ram_we) begin
        if (exp_q.size() == 0) check("spurious_ram_we", {31'b0, ram_we}, 32'd0);
        else check("ram_write", {8'h0, ram_addr, ram_wdata}, {8'h0, exp_q.pop_front()});
      end
      if (tx_start) begin
        n_tx++;
        check("tx_start_while_busy", {31'b0, tx_busy}, 32'd0);
        if (tx_q.size() == 0) check("spurious_tx_start", {31'b0, tx_start}, 32'd0);
        else check("tx_data", {24'b0, tx_data}, {24'b0, tx_q.pop_front()});
        last_tx = tx_data;
      end else begin
        check("tx_data_hold", {24'b0, tx_data}, {24'b0, last_tx});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_checks();
    check("rst_state", {29'b0, state}, 32'd0);
    check("rst_fin", {31'b0, fin}, 32'd0);
    check("rst_ram_we", {31'b0, ram_we}, 32'd0);
    check("rst_ram_addr", {16'b0, ram_addr}, 32'd0);
    check("rst_ram_wdata", {24'b0, ram_wdata}, 32'd0);
    check("rst_tx_start", {31'b0, tx_start}, 32'd0);
    check("rst_tx_data", {24'b0, tx_data}, 32'd0);
    check("rst_ds_start", {31'b0, ds_start}, 32'd0);
  endtask

  // gap=0 picks a random spacing per byte; abort_after>=0 returns once that many bytes are sent
  task automatic run_frame(input int gap, input bit incr, input bit spurious, input bit ds_wr,
                           input bit early_done, input int abort_after);
    logic [7:0] b;
    int         g_len;
    int         tx_base;
    tx_base = n_tx;
    start = 1'b1;
    step();
    start = 1'b0;
    check("load_entry_state", {29'b0, state}, 32'd1);
    check("load_entry_fin", {31'b0, fin}, 32'd0);
    for (int i = 0; i < IMG_BYTES; i++) begin
      b = incr ? 8'(i) : 8'($urandom);
      ref_mem[i] = b;
      exp_q.push_back({16'(i), b});
      rx_valid = 1'b1;
      rx_data  = b;
      step();
      rx_valid = 1'b0;
      g_len = (gap == 0) ? $urandom_range(2, 5) : gap;
      if (i != IMG_BYTES - 1) begin
        for (int g = 1; g < g_len; g++) begin
          if (spurious) begin
            start   = 1'($urandom_range(0, 1));
            ds_done = 1'($urandom_range(0, 1));
          end
          step();
          start   = 1'b0;
          ds_done = 1'b0;
          check("load_hold_state", {29'b0, state}, 32'd1);
        end
      end
    end
    check("proc_entry_state", {29'b0, state}, 32'd2);
    check("ds_start_pulse", {31'b0, ds_start}, 32'd1);
    ds_done  = early_done;
    rx_valid = spurious;
    step();
    ds_done  = 1'b0;
    rx_valid = 1'b0;
    check("proc_hold_state", {29'b0, state}, 32'd2);
    check("ds_start_single", {31'b0, ds_start}, 32'd0);
    if (ds_wr) begin
      ref_mem[2] = 8'hAA;
      exp_q.push_back({16'h0002, 8'hAA});
      ds_addr  = 16'h0002;
      ds_wdata = 8'hAA;
      ds_we    = 1'b1;
      #1;
      check("mux_addr", {16'b0, ram_addr}, 32'h2);
      check("mux_we", {31'b0, ram_we}, 32'd1);
      check("mux_wdata", {24'b0, ram_wdata}, 32'hAA);
      step();
      ds_we = 1'b0;
    end
    repeat (10) step();
    for (int k = 0; k < OUT_BYTES; k++) tx_q.push_back(ref_mem[(OUT_BASE + k) & 255]);
    ds_done = 1'b1;
    step();
    ds_done = 1'b0;
    check("send_entry_state", {29'b0, state}, 32'd3);
    for (int c = 0; c < 3000 && state != 3'd7; c++) begin
      if (abort_after >= 0 && (n_tx - tx_base) >= abort_after) break;
      if (spurious) begin
        rx_valid = 1'($urandom_range(0, 1));
        ds_done  = 1'($urandom_range(0, 1));
        start    = 1'($urandom_range(0, 1));
        rx_data  = 8'($urandom);
      end
      step();
      rx_valid = 1'b0;
      ds_done  = 1'b0;
      start    = 1'b0;
    end
    if (abort_after < 0) begin
      check("done_state", {29'b0, state}, 32'd7);
      check("done_fin", {31'b0, fin}, 32'd1);
      check("tx_count", n_tx - tx_base, OUT_BYTES);
      check("tx_q_drained", tx_q.size(), 32'd0);
      check("writes_drained", exp_q.size(), 32'd0);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    for (int i = 0; i < 256; i++) ram[i] = '0;
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = '0;
    ds_done = 1'b0; ds_addr = '0; ds_we = 1'b0; ds_wdata = '0;
    repeat (2) step();
    rst = 1'b0;
    reset_checks();

    // basic frame, then restart from DONE with an identical frame
    tx_hold = 2;
    run_frame(3, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    run_frame(3, 1'b1, 1'b0, 1'b0, 1'b0, -1);

    // downsampler write through the port mux
    run_frame(3, 1'b1, 1'b0, 1'b1, 1'b0, -1);

    // back-pressure with random data, random spacing and spurious inputs
    tx_hold = 20;
    run_frame(0, 1'b0, 1'b1, 1'b1, 1'b1, -1);
    run_frame(0, 1'b0, 1'b1, 1'b0, 1'b1, -1);

    // reset after two of four bytes are sent
    tx_hold = 5;
    run_frame(0, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    tx_q.delete();
    last_tx = '0;
    reset_checks();
    check("abort_writes_drained", exp_q.size(), 32'd0);
    repeat (40) step();
    check("abort_idle_state", {29'b0, state}, 32'd0);
    run_frame(0, 1'b0, 1'b0, 1'b1, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
